// File: rtl/rx_pkg.sv
// Shared rx/tx definitions: default widths and the receiver FSM encoding.
package rx_pkg;

  localparam int unsigned DW_DEF    = 2;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [1:0] {
    RST_STATE  = 2'b00,
    RX_STATE   = 2'b01,
    FULL_STATE = 2'b10
  } state_t;

endpackage

// File: rtl/rx_if.sv
// Upstream handshake, consumer handshake and status bundle for the receiver.
interface rx_if
  import rx_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) ();

  logic             valid_i;
  logic [DW-1:0]    data_i;
  logic             ready_o;
  logic             out_valid_o;
  logic [DW-1:0]    out_data_o;
  logic             out_ready_i;
  logic             full_o;
  logic             empty_o;
  logic [CNT_W-1:0] rx_count_o;

  modport slave (
    input  valid_i, data_i, out_ready_i,
    output ready_o, out_valid_o, out_data_o, full_o, empty_o, rx_count_o
  );

  modport master (
    output valid_i, data_i, out_ready_i,
    input  ready_o, out_valid_o, out_data_o, full_o, empty_o, rx_count_o
  );

endinterface

// File: rtl/rx_fifo.sv
// First-word-fall-through buffer: storage, wrapping pointers and occupancy.
module rx_fifo
  import rx_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [DW-1:0]          i_data,
  output logic [DW-1:0]          o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Guard against illegal requests so pointers and occupancy never corrupt.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/rx.sv
// Receiver top: accept FSM, registered ready and accepted-word counter around rx_fifo.
module rx
  import rx_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input logic clk,
  input logic rst,
  rx_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t           r_state;
  state_t           w_next;
  logic             r_ready;
  logic [CNT_W-1:0] r_rx_count;
  logic             w_push;
  logic             w_pop;
  logic [DW-1:0]    w_data;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;

  assign w_push = bus.valid_i && r_ready;
  assign w_pop  = !w_empty && bus.out_ready_i;

  rx_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.data_i),
    .o_data  (w_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RST_STATE;
      r_ready    <= 1'b0;
      r_rx_count <= '0;
    end else begin
      r_state <= w_next;
      // Ready is a registered image of the next state.
      r_ready <= (w_next == RX_STATE);
      if (w_push) r_rx_count <= r_rx_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RST_STATE:  w_next = RX_STATE;
      RX_STATE:   if (w_push && !w_pop && (w_count == CW'(DEPTH - 1))) w_next = FULL_STATE;
      FULL_STATE: if (w_pop) w_next = RX_STATE;
      default:    w_next = RST_STATE;
    endcase
  end

  assign bus.ready_o     = r_ready;
  assign bus.out_valid_o = !w_empty;
  assign bus.out_data_o  = w_data;
  assign bus.full_o      = w_full;
  assign bus.empty_o     = w_empty;
  assign bus.rx_count_o  = r_rx_count;

endmodule

// File: tb/tb_rx.sv
// Directed self-checking bench for rx with DW=2, DEPTH=4.
module tb_rx;
  import rx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  rx_if #(.DW(2)) bus ();

  rx #(.DW(2), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  logic [1:0] fill [4];
  logic [1:0] part [3];

  initial begin
    fill = '{2'b01, 2'b10, 2'b11, 2'b01};
    part = '{2'b10, 2'b11, 2'b00};
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i = 2'b00;
    bus.out_ready_i = 1'b0;
    repeat (2) step();

    check("rst_ready",  32'(bus.ready_o), 32'd0);
    check("rst_empty",  32'(bus.empty_o), 32'd1);
    check("rst_full",   32'(bus.full_o), 32'd0);
    check("rst_oval",   32'(bus.out_valid_o), 32'd0);
    check("rst_cnt",    32'(bus.rx_count_o), 32'd0);

    // Release: ready stays low for the RST_STATE cycle, then rises.
    rst = 1'b0;
    #1;
    check("rel_ready0", 32'(bus.ready_o), 32'd0);
    check("rel_state0", 32'(dut.r_state), 32'(RST_STATE));
    step();
    check("rel_ready1", 32'(bus.ready_o), 32'd1);
    check("rel_state1", 32'(dut.r_state), 32'(RX_STATE));
    check("rel_empty",  32'(bus.empty_o), 32'd1);
    check("rel_cnt",    32'(bus.rx_count_o), 32'd0);

    // Single push falls through to the output next cycle.
    bus.valid_i = 1'b1;
    bus.data_i = 2'b01;
    step();
    bus.valid_i = 1'b0;
    check("one_oval",  32'(bus.out_valid_o), 32'd1);
    check("one_data",  32'(bus.out_data_o), 32'd1);
    check("one_cnt",   32'(bus.rx_count_o), 32'd1);
    check("one_empty", 32'(bus.empty_o), 32'd0);
    bus.out_ready_i = 1'b1;
    step();
    check("one_popped", 32'(bus.empty_o), 32'd1);
    // Pop while empty has no effect.
    step();
    bus.out_ready_i = 1'b0;
    check("empty_pop_occ",  32'(dut.u_fifo.r_count), 32'd0);
    check("empty_pop_oval", 32'(bus.out_valid_o), 32'd0);
    check("empty_pop_cnt",  32'(bus.rx_count_o), 32'd1);

    // Fill to DEPTH, then attempt a fifth push.
    do_reset();
    check("re_cnt",   32'(bus.rx_count_o), 32'd0);
    check("re_ready", 32'(bus.ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.valid_i = 1'b1;
      bus.data_i = fill[i];
      step();
    end
    bus.valid_i = 1'b0;
    check("full_full",  32'(bus.full_o), 32'd1);
    check("full_state", 32'(dut.r_state), 32'(FULL_STATE));
    check("full_ready", 32'(bus.ready_o), 32'd0);
    check("full_cnt",   32'(bus.rx_count_o), 32'd4);
    bus.valid_i = 1'b1;
    bus.data_i = 2'b10;
    step();
    bus.valid_i = 1'b0;
    check("fifth_cnt",  32'(bus.rx_count_o), 32'd4);
    check("fifth_occ",  32'(dut.u_fifo.r_count), 32'd4);
    check("fifth_head", 32'(bus.out_data_o), 32'd1);

    // One pop from full reopens ready; drain in order.
    bus.out_ready_i = 1'b1;
    step();
    check("pop_ready", 32'(bus.ready_o), 32'd1);
    check("pop_full",  32'(bus.full_o), 32'd0);
    check("pop_state", 32'(dut.r_state), 32'(RX_STATE));
    for (int i = 1; i < 4; i++) begin
      check($sformatf("drain_%0d", i), 32'(bus.out_data_o), 32'(fill[i]));
      step();
    end
    bus.out_ready_i = 1'b0;
    check("drain_empty", 32'(bus.empty_o), 32'd1);
    check("drain_cnt",   32'(bus.rx_count_o), 32'd4);

    // Occupancy 3 with simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      bus.valid_i = 1'b1;
      bus.data_i = part[i];
      step();
    end
    check("occ3",      32'(dut.u_fifo.r_count), 32'd3);
    check("occ3_head", 32'(bus.out_data_o), 32'd2);
    bus.valid_i = 1'b1;
    bus.data_i = 2'b01;
    bus.out_ready_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    check("pp_occ",   32'(dut.u_fifo.r_count), 32'd3);
    check("pp_state", 32'(dut.r_state), 32'(RX_STATE));
    check("pp_full",  32'(bus.full_o), 32'd0);
    check("pp_ready", 32'(bus.ready_o), 32'd1);
    check("pp_head",  32'(bus.out_data_o), 32'd3);
    check("pp_cnt",   32'(bus.rx_count_o), 32'd8);
    bus.out_ready_i = 1'b1;
    check("pp_d0", 32'(bus.out_data_o), 32'd3);
    step();
    check("pp_d1", 32'(bus.out_data_o), 32'd0);
    step();
    check("pp_d2", 32'(bus.out_data_o), 32'd1);
    step();
    bus.out_ready_i = 1'b0;
    check("pp_empty", 32'(bus.empty_o), 32'd1);

    // 256 accepted words wrap the counter.
    do_reset();
    bus.valid_i = 1'b1;
    bus.data_i = 2'b11;
    bus.out_ready_i = 1'b1;
    repeat (255) step();
    check("cnt_255", 32'(bus.rx_count_o), 32'd255);
    step();
    check("cnt_wrap", 32'(bus.rx_count_o), 32'd0);
    bus.out_ready_i = 1'b0;
    bus.data_i = 2'b10;
    step();
    bus.valid_i = 1'b0;
    check("two_occ", 32'(dut.u_fifo.r_count), 32'd2);
    check("two_cnt", 32'(bus.rx_count_o), 32'd1);

    // Mid-cycle reset clears everything without a clock edge.
    #3;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(bus.ready_o), 32'd0);
    check("arst_oval",  32'(bus.out_valid_o), 32'd0);
    check("arst_empty", 32'(bus.empty_o), 32'd1);
    check("arst_full",  32'(bus.full_o), 32'd0);
    check("arst_cnt",   32'(bus.rx_count_o), 32'd0);
    check("arst_state", 32'(dut.r_state), 32'(RST_STATE));
    check("arst_occ",   32'(dut.u_fifo.r_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
